// File: rtl/decode_stage_pkg.sv
// Shared MIPS decode constants: the canonical bubble instruction, opcodes and field slicers.
package decode_stage_pkg;

  localparam logic [31:0] no_op = 32'h0000_0020;  // add $0,$0,$0

  localparam logic [5:0] ALUop = 6'h00;
  localparam logic [5:0] J     = 6'h02;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] BNE   = 6'h05;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;

  function automatic logic [5:0] op_of(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] rs_of(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [31:0] sext_imm(input logic [31:0] ir);
    return {{16{ir[15]}}, ir[15:0]};
  endfunction

endpackage

// File: rtl/decode_stage_regfile32.sv
// 32x32 register file: two async read ports with write-first bypass, one sync write port, $0 hardwired.
module regfile32 (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra_addr,
  output logic [31:0] ra_data,
  input  logic [4:0]  rb_addr,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_live;

  assign wr_live = we && (wa != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // A same-cycle write to the addressed register is forwarded so decode sees the new value.
  always_comb begin
    ra_data = '0;
    if (ra_addr != '0) ra_data = (wr_live && wa == ra_addr) ? wd : regs_q[ra_addr];
  end

  always_comb begin
    rb_data = '0;
    if (rb_addr != '0) rb_data = (wr_live && wa == rb_addr) ? wd : regs_q[rb_addr];
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: operand read, load-use stall detection, sign extension and the ID/EX latch.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IFIDIR,
  input  logic        ijmpMem,
  input  logic        wbEn,
  input  logic [4:0]  wbReg,
  input  logic [31:0] wbData,
  output logic        stall,
  output logic [31:0] IDEXIR,
  output logic [31:0] IDEXA,
  output logic [31:0] IDEXB,
  output logic [31:0] IDEXimm
);

  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] rs_data, rt_data;
  logic [4:0]  rs_addr, rt_addr, ex_rt;
  logic [5:0]  id_op;
  logic        uses_rs, uses_rt, load_use;

  assign rs_addr = rs_of(IFIDIR);
  assign rt_addr = rt_of(IFIDIR);

  regfile32 u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (rs_addr),
    .ra_data (rs_data),
    .rb_addr (rt_addr),
    .rb_data (rt_data),
    .we      (wbEn),
    .wa      (wbReg),
    .wd      (wbData)
  );

  always_comb begin
    id_op    = op_of(IFIDIR);
    ex_rt    = rt_of(ir_q);
    uses_rs  = (id_op != J);
    uses_rt  = id_op inside {ALUop, BEQ, BNE, SW};
    load_use = (op_of(ir_q) == LW) && (ex_rt != '0) &&
               ((uses_rs && rs_addr == ex_rt) || (uses_rt && rt_addr == ex_rt));
  end

  // A flush from MEM discards the dependent instruction anyway, so it masks the stall.
  assign stall = load_use & ~ijmpMem;

  always_comb begin
    ir_d  = IFIDIR;
    a_d   = rs_data;
    b_d   = rt_data;
    imm_d = sext_imm(IFIDIR);
    if (ijmpMem || stall) begin
      ir_d  = no_op;
      a_d   = '0;
      b_d   = '0;
      imm_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q  <= no_op;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
    end else begin
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      imm_q <= imm_d;
    end
  end

  assign IDEXIR  = ir_q;
  assign IDEXA   = a_q;
  assign IDEXB   = b_q;
  assign IDEXimm = imm_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the five-stage MIPS pipeline and the consumer of the fetch stage's IF/ID instruction register. It holds the 32×32 register file, reads operands for the instruction in `IFIDIR`, and registers them with the instruction and sign-extended immediate into the ID/EX latch. It also detects load-use hazards and drives the `stall` signal back to fetch, inserting a bubble into ID/EX on each stalled cycle. On a taken jump or branch (`ijmpMem`), it flushes its own latch.

## Interface
Parameters: none. Opcodes and `no_op` (32'h0000_0020, `add $0,$0,$0`) come from the shared parameters file.

- `clk` in 1: single pipeline clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `IFIDIR` in 32: instruction from the IF/ID latch.
- `ijmpMem` in 1: control transfer resolved in MEM; flush request.
- `wbEn` in 1: register-file write enable from WB.
- `wbReg` in 5: WB destination register.
- `wbData` in 32: WB write data.
- `stall` out 1: combinational load-use stall to fetch and the PC.
- `IDEXIR` out 32: ID/EX instruction.
- `IDEXA` out 32: rs operand.
- `IDEXB` out 32: rt operand.
- `IDEXimm` out 32: sign-extended `IFIDIR[15:0]`.

## Operation
- **Fields:** `op=[31:26]`, `rs=[25:21]`, `rt=[20:16]`.
- **Source usage:**
  - `usesRs` = op is not J (6'h02).
  - `usesRt` = op ∈ {R-type 6'h00, BEQ 6'h04, BNE 6'h05, SW 6'h2B}.
- **Load-use detection:**
  - `loadUse` = `IDEXIR.op==LW(6'h23)` and `IDEXIR.rt != 0`, and either (`usesRs` and `rs==IDEXIR.rt`) or (`usesRt` and `rt==IDEXIR.rt`).
  - `stall = loadUse & ~ijmpMem`.
- **Register file:**
  - Writes on the clock edge when `wbEn` and `wbReg != 0`.
  - Register 0 always reads 0.
  - Reads are write-first: if `wbEn`, `wbReg==rs`, and `rs != 0`, then A takes `wbData` this cycle. B follows the same rule with rt.
- **ID/EX update priority** (highest first):
  1. `reset`: `IDEXIR=no_op`; A, B, imm = 0; all 32 registers cleared.
  2. `ijmpMem`: `IDEXIR<=no_op`; A, B, imm <= 0.
  3. `stall`: bubble, `IDEXIR<=no_op`; A, B, imm <= 0.
  4. Otherwise: `IDEXIR<=IFIDIR`, `IDEXA/B<=` bypassed reads, `IDEXimm<={{16{IFIDIR[15]}},IFIDIR[15:0]}`.
- The register-file write proceeds in every non-reset cycle, including flush and stall cycles.

## Timing
- Latency: 1 cycle from `IFIDIR` to the ID/EX outputs.
- `stall` is combinational from `IFIDIR`, `IDEXIR`, and `ijmpMem`. It has no registered state.
- A single load-use hazard stalls for exactly one cycle. The bubble makes `IDEXIR=no_op`, which drops `stall` on the next cycle while fetch holds `IFIDIR`.
- Back-to-back loads each cause at most one stall cycle.
- `ijmpMem` together with a load-use condition: the flush wins and `stall=0`.
- Reset assertion mid-stall or mid-flush clears everything immediately. `stall` reads 0 after reset because `IDEXIR=no_op`.
- Write and read of the same register in the same cycle returns the new value.

## Structure
- The shared parameters package holds: `no_op`, opcodes `LW/SW/BEQ/BNE/J/ADDI/ALUop`, and field-slice helper functions.
- One sub-module, `regfile32`: 2 async-read ports, 1 sync-write port, async reset, write-first bypass, $0 hardwired.
- `decode_stage` itself holds the hazard logic, sign extension, and the ID/EX latch.

## Test plan
- **Reset:** assert `reset` mid-cycle → outputs immediately `IDEXIR=32'h20`, A=B=imm=0, `stall=0`; reading any register afterwards gives 0.
- **WB bypass:** `wbEn=1`, `wbReg=5`, `wbData=32'hDEAD_BEEF`, with `IFIDIR=add $3,$5,$0` in the same cycle → next edge `IDEXA=32'hDEAD_BEEF`, `IDEXB=0`. A write with `wbReg=0` leaves $0 reading 0.
- **Load-use:**
  - Setup: `lw $2,4($1)` then `add $4,$2,$3`.
  - When `IDEXIR` holds the lw: `stall=1` for one cycle and `IDEXIR` becomes `no_op`.
  - Next cycle: `stall=0` and the add enters ID/EX.
  - Repeat with `sw $2,0($6)` (rt use) → stalls; `addi $2,$2,1` following `lw $0,...` → no stall.
- **Flush priority:** raise `ijmpMem` in the same cycle as a load-use condition → `stall=0` and `IDEXIR=no_op`.
- **Sign extension:** `IFIDIR=addi $1,$0,-4` (imm 16'hFFFC) → `IDEXimm=32'hFFFF_FFFC`; imm 16'h7FFF → `32'h0000_7FFF`.
